ctrl_sequencer: RTL and testbench

Microcoded control unit for the 8-bit CPU datapath: an 8-phase one-hot timing generator plus a combinational decoder. The decoder turns the current phase T, a one-hot instruction vector `ctrl` and two one-hot register selects into the datapath strobes: register in/out enables, ALU op selects, memory/MAR/PC/IR controls and jump strobes. It sits between the instruction decoder and the datapath.

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/ctrl_sequencer_phase_gen.sv | 26 ++
 rtl/ctrl_sequencer.sv | 97 +++++++++
 tb/tb_ctrl_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: instruction-class bit indices, phase indices and a one-hot helper
// shared by the sequencer and its phase generator.
package ctrl_pkg;

   // ctrl vector bit positions
   localparam int C_NOP   = 0;
   localparam int C_MOV   = 1;
   localparam int C_LOAD  = 2;
   localparam int C_STORE = 3;
   localparam int C_LDI   = 4;
   localparam int C_ADD   = 5;
   localparam int C_SUB   = 6;
   localparam int C_ADC   = 7;
   localparam int C_SBB   = 8;
   localparam int C_MUL   = 9;
   localparam int C_DIV   = 10;
   localparam int C_INC   = 11;
   localparam int C_DEC   = 12;
   localparam int C_SHL   = 13;
   localparam int C_SHR   = 14;
   localparam int C_NOT   = 15;
   localparam int C_NEG   = 16;
   localparam int C_AND   = 17;
   localparam int C_OR    = 18;
   localparam int C_JMP   = 19;
   localparam int C_JA    = 20;
   localparam int C_JB    = 21;
   localparam int C_JE    = 22;
   localparam int C_SAVEF = 23;
   localparam int C_LOADF = 24;
   localparam int C_LDA   = 25;
   localparam int C_STA   = 26;
   localparam int C_RSV   = 27;

   // timing phase bit positions in T
   localparam int T0 = 0;
   localparam int T1 = 1;
   localparam int T2 = 2;
   localparam int T3 = 3;
   localparam int T4 = 4;
   localparam int T5 = 5;
   localparam int T6 = 6;
   localparam int T7 = 7;

   // true when exactly one bit of v is set
   function automatic logic is_onehot8(input logic [7:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return (n == 1);
   endfunction

endpackage

// File: rtl/ctrl_sequencer_phase_gen.sv
// phase_gen: 8-phase one-hot ring counter, self-recovering to T0 from any
// illegal (non one-hot) state.
module phase_gen
   import ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] T
);

   logic [7:0] t_q, t_d;

   // next phase: rotate left, or restart at T0 on reset / corrupted ring
   always_comb begin
      t_d = 8'h01;
      if (rst && is_onehot8(t_q)) t_d = {t_q[6:0], t_q[7]};
   end

   // phase register
   always_ff @(posedge clk) begin
      t_q <= t_d;
   end

   assign T = t_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: timing generator plus combinational microcode decode of
// phase, instruction class and register selects into datapath strobes.
module ctrl_sequencer
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [27:0] ctrl,
   input  logic [3:0]  Tgt1,
   input  logic [3:0]  Tgt2,
   output logic [7:0]  T,
   output logic IA, IB,
   output logic IADD, ISUB, IADC, ISBB, IMUL, IDIV, IINC, IDEC,
   output logic ISHL, ISHR, INOT, INEG, IAND, IOR,
   output logic IJMP, IJA, IJB, IJE,
   output logic EALU,
   output logic I0, I1, I2, I3,
   output logic E0, E1, E2, E3,
   output logic IF, EF,
   output logic IDFR, IDFB,
   output logic EDTB,
   output logic iwr,
   output logic IPC,
   output logic IMPC,
   output logic IMAR,
   output logic IIR,
   output logic IMARB
);

   phase_gen u_pg (.clk(clk), .rst(rst), .T(T));

   // instruction groups sharing a microcode shape
   logic binop, unop, jmp, imm_fetch, rd_data;
   logic rd_in, rd_out, rs_out;
   logic [3:0] reg_in, reg_out;
   logic unused_ok;

   assign binop     = |{ctrl[C_DIV:C_ADD], ctrl[C_OR:C_AND]};
   assign unop      = |ctrl[C_NEG:C_INC];
   assign jmp       = |ctrl[C_JE:C_JMP];
   assign imm_fetch = ctrl[C_LDI] | jmp;                  // operand byte follows opcode
   assign rd_data   = ctrl[C_LOAD] | ctrl[C_LDA] | imm_fetch; // RAM -> data reg -> bus
   assign unused_ok = ^{ctrl[C_NOP], ctrl[C_RSV]};

   // fetch, addressing and memory strobes
   assign IMPC  = T[T0] | (T[T2] & imm_fetch);
   assign IIR   = T[T1];
   assign IPC   = T[T1] | (T[T3] & imm_fetch);
   assign IMAR  = T[T2] & (ctrl[C_LOAD] | ctrl[C_STORE]);
   assign IMARB = T[T2] & (ctrl[C_LDA] | ctrl[C_STA]);
   assign IDFR  = T[T3] & rd_data;
   assign EDTB  = T[T4] & rd_data;
   assign IDFB  = T[T3] & (ctrl[C_STORE] | ctrl[C_STA]);
   assign iwr   = T[T4] & (ctrl[C_STORE] | ctrl[C_STA]);

   // ALU operand loads and result phase (T4 for binary, T3 for unary)
   assign IA   = T[T2] & (binop | unop);
   assign IB   = T[T3] & binop;
   assign EALU = (T[T4] & binop) | (T[T3] & unop);
   assign IF   = EALU | (T[T2] & ctrl[C_LOADF]);
   assign EF   = T[T2] & ctrl[C_SAVEF];

   assign IADD = T[T4] & ctrl[C_ADD];
   assign ISUB = T[T4] & ctrl[C_SUB];
   assign IADC = T[T4] & ctrl[C_ADC];
   assign ISBB = T[T4] & ctrl[C_SBB];
   assign IMUL = T[T4] & ctrl[C_MUL];
   assign IDIV = T[T4] & ctrl[C_DIV];
   assign IAND = T[T4] & ctrl[C_AND];
   assign IOR  = T[T4] & ctrl[C_OR];
   assign IINC = T[T3] & ctrl[C_INC];
   assign IDEC = T[T3] & ctrl[C_DEC];
   assign ISHL = T[T3] & ctrl[C_SHL];
   assign ISHR = T[T3] & ctrl[C_SHR];
   assign INOT = T[T3] & ctrl[C_NOT];
   assign INEG = T[T3] & ctrl[C_NEG];

   // PC load from bus; condition is evaluated inside the PC
   assign IJMP = T[T4] & ctrl[C_JMP];
   assign IJA  = T[T4] & ctrl[C_JA];
   assign IJB  = T[T4] & ctrl[C_JB];
   assign IJE  = T[T4] & ctrl[C_JE];

   // register file strobes: Rd may load or drive, Rs only drives
   assign rd_in  = (T[T2] & (ctrl[C_MOV] | ctrl[C_SAVEF])) |
                   (T[T4] & rd_data & ~jmp) | EALU;
   assign rd_out = T[T2] & (binop | unop | ctrl[C_STA]);
   assign rs_out = (T[T2] & (ctrl[C_MOV] | ctrl[C_LOADF] | ctrl[C_LDA])) |
                   (T[T3] & (binop | ctrl[C_STORE] | ctrl[C_STA]));

   assign reg_in  = {4{rd_in}} & Tgt1;
   assign reg_out = ({4{rd_out}} & Tgt1) | ({4{rs_out}} & Tgt2);

   assign {I3, I2, I1, I0} = reg_in;
   assign {E3, E2, E1, E0} = reg_out;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed instruction windows plus random ones,
// every cycle compared with a per-instruction microcode table model.
module tb_ctrl_sequencer;

   // strobe positions in the observation vector
   localparam int S_IA = 0, S_IB = 1;           // ALU ops: ctrl bit b (5..18) -> b-3
   localparam int S_EALU = 20, S_I0 = 21, S_E0 = 25;  // jumps: ctrl 19..22 -> 16..19
   localparam int S_IF = 29, S_EF = 30, S_IDFR = 31, S_IDFB = 32, S_EDTB = 33;
   localparam int S_IWR = 34, S_IPC = 35, S_IMPC = 36, S_IMAR = 37, S_IIR = 38, S_IMARB = 39;

   logic clk = 1'b0, rst = 1'b0;
   logic [27:0] ctrl = '0;
   logic [3:0]  Tgt1 = '0, Tgt2 = '0;
   logic [7:0]  T;
   logic IA, IB, IADD, ISUB, IADC, ISBB, IMUL, IDIV, IINC, IDEC, ISHL, ISHR, INOT, INEG, IAND, IOR;
   logic IJMP, IJA, IJB, IJE, EALU, I0, I1, I2, I3, E0, E1, E2, E3;
   logic IF, EF, IDFR, IDFB, EDTB, iwr, IPC, IMPC, IMAR, IIR, IMARB;
   logic [39:0] obs;

   int vectors = 0, miscompares = 0, ph = 0;

   always #5 clk = ~clk;

   ctrl_sequencer dut (
      .clk(clk), .rst(rst), .ctrl(ctrl), .Tgt1(Tgt1), .Tgt2(Tgt2), .T(T),
      .IA(IA), .IB(IB), .IADD(IADD), .ISUB(ISUB), .IADC(IADC), .ISBB(ISBB),
      .IMUL(IMUL), .IDIV(IDIV), .IINC(IINC), .IDEC(IDEC), .ISHL(ISHL), .ISHR(ISHR),
      .INOT(INOT), .INEG(INEG), .IAND(IAND), .IOR(IOR),
      .IJMP(IJMP), .IJA(IJA), .IJB(IJB), .IJE(IJE), .EALU(EALU),
      .I0(I0), .I1(I1), .I2(I2), .I3(I3), .E0(E0), .E1(E1), .E2(E2), .E3(E3),
      .IF(IF), .EF(EF), .IDFR(IDFR), .IDFB(IDFB), .EDTB(EDTB), .iwr(iwr),
      .IPC(IPC), .IMPC(IMPC), .IMAR(IMAR), .IIR(IIR), .IMARB(IMARB)
   );

   assign obs = {IMARB, IIR, IMAR, IMPC, IPC, iwr, EDTB, IDFB, IDFR, EF, IF,
                 E3, E2, E1, E0, I3, I2, I1, I0, EALU, IJE, IJB, IJA, IJMP,
                 IOR, IAND, INEG, INOT, ISHR, ISHL, IDEC, IINC, IDIV, IMUL,
                 ISBB, IADC, ISUB, IADD, IB, IA};

   // expected strobes for phase p: fetch, then OR of each set instruction's table row
   function automatic logic [39:0] model(input int p, input logic [27:0] c,
                                         input logic [3:0] d, input logic [3:0] s);
      logic [39:0] e;
      logic [3:0] rin, rout;
      e = '0; rin = '0; rout = '0;
      if (p == 0) e[S_IMPC] = 1'b1;
      if (p == 1) begin e[S_IIR] = 1'b1; e[S_IPC] = 1'b1; end
      for (int b = 0; b < 28; b++) begin
         if (!c[b]) continue;
         if (b == 1 && p == 2) begin rout |= s; rin |= d; end
         if (b == 2 || b == 25) begin
            if (p == 2 && b == 2) e[S_IMAR] = 1'b1;
            if (p == 2 && b == 25) begin rout |= s; e[S_IMARB] = 1'b1; end
            if (p == 3) e[S_IDFR] = 1'b1;
            if (p == 4) begin e[S_EDTB] = 1'b1; rin |= d; end
         end
         if (b == 3 || b == 26) begin
            if (p == 2 && b == 3) e[S_IMAR] = 1'b1;
            if (p == 2 && b == 26) begin rout |= d; e[S_IMARB] = 1'b1; end
            if (p == 3) begin rout |= s; e[S_IDFB] = 1'b1; end
            if (p == 4) e[S_IWR] = 1'b1;
         end
         if (b == 4 || (b >= 19 && b <= 22)) begin
            if (p == 2) e[S_IMPC] = 1'b1;
            if (p == 3) begin e[S_IDFR] = 1'b1; e[S_IPC] = 1'b1; end
            if (p == 4) begin
               e[S_EDTB] = 1'b1;
               if (b == 4) rin |= d; else e[b-3] = 1'b1;
            end
         end
         if ((b >= 5 && b <= 10) || b == 17 || b == 18) begin
            if (p == 2) begin rout |= d; e[S_IA] = 1'b1; end
            if (p == 3) begin rout |= s; e[S_IB] = 1'b1; end
            if (p == 4) begin e[b-3] = 1'b1; e[S_EALU] = 1'b1; rin |= d; e[S_IF] = 1'b1; end
         end
         if (b >= 11 && b <= 16) begin
            if (p == 2) begin rout |= d; e[S_IA] = 1'b1; end
            if (p == 3) begin e[b-3] = 1'b1; e[S_EALU] = 1'b1; rin |= d; e[S_IF] = 1'b1; end
         end
         if (b == 23 && p == 2) begin e[S_EF] = 1'b1; rin |= d; end
         if (b == 24 && p == 2) begin rout |= s; e[S_IF] = 1'b1; end
      end
      e[S_I0 +: 4] = rin;
      e[S_E0 +: 4] = rout;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [39:0] o, input logic [39:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s ph=%0d ctrl=%h t1=%b t2=%b observed=%h expected=%h",
                tag, ph, ctrl, Tgt1, Tgt2, o, e);
      end
   endtask

   // advance one clock and check phase plus every strobe
   task automatic step();
      @(posedge clk); #1;
      ph = (ph + 1) % 8;
      chk("phase", {32'h0, T}, {32'h0, 8'h01 << ph});
      chk("strobes", obs, model(ph, ctrl, Tgt1, Tgt2));
   endtask

   // run one full T0..T7 window with inputs applied during the preceding T7
   task automatic window(input logic [27:0] c, input logic [3:0] d, input logic [3:0] s);
      while (ph != 7) step();
      ctrl = c; Tgt1 = d; Tgt2 = s;
      #1;
      chk("strobes_pre", obs, model(7, ctrl, Tgt1, Tgt2));
      repeat (8) step();
   endtask

   initial begin
      // reset held for two clocks
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_phase", {32'h0, T}, 40'h01);
         chk("rst_strobes", obs, model(0, ctrl, Tgt1, Tgt2));
      end
      @(negedge clk); rst = 1'b1; ph = 0;

      // free run one full ring, then directed instruction windows
      repeat (8) step();
      window(28'd1 << 15, 4'b0001, 4'b1000);   // NOT
      window(28'd1 << 9,  4'b0001, 4'b0000);   // MUL
      window(28'd1 << 25, 4'b0001, 4'b0000);   // LDA
      window(28'd1 << 12, 4'b0001, 4'b0000);   // DEC
      window(28'd1 << 0,  4'b0001, 4'b0000);   // NOP
      window(28'd1 << 3,  4'b0000, 4'b0100);   // STORE
      window(28'd1 << 21, 4'b0000, 4'b0000);   // JB
      window(28'd1 << 27, 4'b1111, 4'b1111);   // reserved
      window(28'd0,       4'b1111, 4'b1111);   // no class
      window((28'd1 << 1) | (28'd1 << 23), 4'b0010, 4'b0100); // MOV|SAVEF

      // corrupt the ring to a two-hot value: must recover to T0
      @(negedge clk);
      force dut.u_pg.t_q = 8'h03;
      #1 chk("forced_phase", {32'h0, T}, 40'h03);
      release dut.u_pg.t_q;
      @(posedge clk); #1;
      chk("recover_phase", {32'h0, T}, 40'h01);
      ph = 0;

      // random windows, mostly one-hot class, sometimes two classes
      for (int n = 0; n < 60; n++) begin
         logic [27:0] c;
         c = 28'd1 << $urandom_range(0, 27);
         if ($urandom_range(0, 3) == 0) c |= 28'd1 << $urandom_range(0, 27);
         window(c, 4'($urandom), 4'($urandom));
      end

      // reset in mid-window: only fetch T0 strobes with arbitrary inputs
      repeat (3) step();
      @(negedge clk); rst = 1'b0;
      ctrl = 28'd1 << 9; Tgt1 = 4'b1111; Tgt2 = 4'b1111;
      repeat (2) begin
         @(posedge clk); #1;
         chk("midrst_phase", {32'h0, T}, 40'h01);
         chk("midrst_strobes", obs, {3'b0, 1'b1, 36'h0});
      end
      @(negedge clk); rst = 1'b1; ph = 0;
      repeat (8) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
